// File: rtl/s_to_p_no_cp.sv
// Receive-side serial-to-parallel converter (no cyclic prefix).
// Captures offset-binary samples into 64-sample symbols, flips the MSB to get
// two's complement, and double-buffers each completed symbol onto Y0..Y63.
module s_to_p_no_cp #(
   parameter int unsigned WIDTH = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic             i_strobe,
   input  logic [WIDTH-1:0] i_X,
   input  logic             i_ack,
   output logic [WIDTH-1:0] Y0,
   output logic [WIDTH-1:0] Y1,
   output logic [WIDTH-1:0] Y2,
   output logic [WIDTH-1:0] Y3,
   output logic [WIDTH-1:0] Y4,
   output logic [WIDTH-1:0] Y5,
   output logic [WIDTH-1:0] Y6,
   output logic [WIDTH-1:0] Y7,
   output logic [WIDTH-1:0] Y8,
   output logic [WIDTH-1:0] Y9,
   output logic [WIDTH-1:0] Y10,
   output logic [WIDTH-1:0] Y11,
   output logic [WIDTH-1:0] Y12,
   output logic [WIDTH-1:0] Y13,
   output logic [WIDTH-1:0] Y14,
   output logic [WIDTH-1:0] Y15,
   output logic [WIDTH-1:0] Y16,
   output logic [WIDTH-1:0] Y17,
   output logic [WIDTH-1:0] Y18,
   output logic [WIDTH-1:0] Y19,
   output logic [WIDTH-1:0] Y20,
   output logic [WIDTH-1:0] Y21,
   output logic [WIDTH-1:0] Y22,
   output logic [WIDTH-1:0] Y23,
   output logic [WIDTH-1:0] Y24,
   output logic [WIDTH-1:0] Y25,
   output logic [WIDTH-1:0] Y26,
   output logic [WIDTH-1:0] Y27,
   output logic [WIDTH-1:0] Y28,
   output logic [WIDTH-1:0] Y29,
   output logic [WIDTH-1:0] Y30,
   output logic [WIDTH-1:0] Y31,
   output logic [WIDTH-1:0] Y32,
   output logic [WIDTH-1:0] Y33,
   output logic [WIDTH-1:0] Y34,
   output logic [WIDTH-1:0] Y35,
   output logic [WIDTH-1:0] Y36,
   output logic [WIDTH-1:0] Y37,
   output logic [WIDTH-1:0] Y38,
   output logic [WIDTH-1:0] Y39,
   output logic [WIDTH-1:0] Y40,
   output logic [WIDTH-1:0] Y41,
   output logic [WIDTH-1:0] Y42,
   output logic [WIDTH-1:0] Y43,
   output logic [WIDTH-1:0] Y44,
   output logic [WIDTH-1:0] Y45,
   output logic [WIDTH-1:0] Y46,
   output logic [WIDTH-1:0] Y47,
   output logic [WIDTH-1:0] Y48,
   output logic [WIDTH-1:0] Y49,
   output logic [WIDTH-1:0] Y50,
   output logic [WIDTH-1:0] Y51,
   output logic [WIDTH-1:0] Y52,
   output logic [WIDTH-1:0] Y53,
   output logic [WIDTH-1:0] Y54,
   output logic [WIDTH-1:0] Y55,
   output logic [WIDTH-1:0] Y56,
   output logic [WIDTH-1:0] Y57,
   output logic [WIDTH-1:0] Y58,
   output logic [WIDTH-1:0] Y59,
   output logic [WIDTH-1:0] Y60,
   output logic [WIDTH-1:0] Y61,
   output logic [WIDTH-1:0] Y62,
   output logic [WIDTH-1:0] Y63,
   output logic             o_valid,
   output logic             o_overrun,
   output logic [5:0]       o_cnt
);

   localparam int unsigned NUM_SAMPLES = 64;
   localparam int unsigned MEM_DEPTH   = NUM_SAMPLES - 1;
   localparam int unsigned CNT_W       = 6;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);
   localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic {
      IDLE    = 1'b0,
      CAPTURE = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;
   logic [WIDTH-1:0] mem_q [MEM_DEPTH];
   logic [WIDTH-1:0] y_q   [NUM_SAMPLES];

   logic [WIDTH-1:0] conv_c;
   logic             wr_en_c;
   logic [CNT_W-1:0] wr_idx_c;
   logic             complete_c;

   // Offset-binary to two's complement is just an MSB flip.
   assign conv_c = i_X ^ MSB_MASK;

   // Next-state, write control and handshake; i_start outranks completion.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      valid_d    = valid_q;
      overrun_d  = overrun_q;
      wr_en_c    = 1'b0;
      wr_idx_c   = cnt_q;
      complete_c = 1'b0;

      if (i_start) begin
         state_d  = CAPTURE;
         cnt_d    = i_strobe ? CNT_W'(1) : '0;
         wr_en_c  = i_strobe;
         wr_idx_c = '0;
      end else if (state_q == CAPTURE && i_strobe) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == LAST_IDX) begin
            complete_c = 1'b1;
         end else begin
            wr_en_c = 1'b1;
         end
      end

      if (complete_c) begin
         valid_d = 1'b1;
         if (valid_q && !i_ack) begin
            overrun_d = 1'b1;
         end
      end else if (i_ack) begin
         valid_d = 1'b0;
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   // Capture buffer for samples 0..62 of the symbol in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en_c) begin
         mem_q[wr_idx_c] <= conv_c;
      end
   end

   // Output bank: loaded as a whole on completion; last sample bypasses the buffer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_SAMPLES; i++) begin
            y_q[i] <= '0;
         end
      end else if (complete_c) begin
         for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
            y_q[i] <= mem_q[i];
         end
         y_q[NUM_SAMPLES-1] <= conv_c;
      end
   end

   assign o_valid   = valid_q;
   assign o_overrun = overrun_q;
   assign o_cnt     = cnt_q;

   assign Y0  = y_q[0];
   assign Y1  = y_q[1];
   assign Y2  = y_q[2];
   assign Y3  = y_q[3];
   assign Y4  = y_q[4];
   assign Y5  = y_q[5];
   assign Y6  = y_q[6];
   assign Y7  = y_q[7];
   assign Y8  = y_q[8];
   assign Y9  = y_q[9];
   assign Y10 = y_q[10];
   assign Y11 = y_q[11];
   assign Y12 = y_q[12];
   assign Y13 = y_q[13];
   assign Y14 = y_q[14];
   assign Y15 = y_q[15];
   assign Y16 = y_q[16];
   assign Y17 = y_q[17];
   assign Y18 = y_q[18];
   assign Y19 = y_q[19];
   assign Y20 = y_q[20];
   assign Y21 = y_q[21];
   assign Y22 = y_q[22];
   assign Y23 = y_q[23];
   assign Y24 = y_q[24];
   assign Y25 = y_q[25];
   assign Y26 = y_q[26];
   assign Y27 = y_q[27];
   assign Y28 = y_q[28];
   assign Y29 = y_q[29];
   assign Y30 = y_q[30];
   assign Y31 = y_q[31];
   assign Y32 = y_q[32];
   assign Y33 = y_q[33];
   assign Y34 = y_q[34];
   assign Y35 = y_q[35];
   assign Y36 = y_q[36];
   assign Y37 = y_q[37];
   assign Y38 = y_q[38];
   assign Y39 = y_q[39];
   assign Y40 = y_q[40];
   assign Y41 = y_q[41];
   assign Y42 = y_q[42];
   assign Y43 = y_q[43];
   assign Y44 = y_q[44];
   assign Y45 = y_q[45];
   assign Y46 = y_q[46];
   assign Y47 = y_q[47];
   assign Y48 = y_q[48];
   assign Y49 = y_q[49];
   assign Y50 = y_q[50];
   assign Y51 = y_q[51];
   assign Y52 = y_q[52];
   assign Y53 = y_q[53];
   assign Y54 = y_q[54];
   assign Y55 = y_q[55];
   assign Y56 = y_q[56];
   assign Y57 = y_q[57];
   assign Y58 = y_q[58];
   assign Y59 = y_q[59];
   assign Y60 = y_q[60];
   assign Y61 = y_q[61];
   assign Y62 = y_q[62];
   assign Y63 = y_q[63];

endmodule

// File: tb/tb_s_to_p_no_cp.sv
// Directed bench for s_to_p_no_cp with hand-computed expected values.
module tb_s_to_p_no_cp;

   localparam int unsigned WIDTH = 10;

   logic             clk;
   logic             reset;
   logic             i_start;
   logic             i_strobe;
   logic [WIDTH-1:0] i_X;
   logic             i_ack;
   logic [WIDTH-1:0] y [64];
   logic             o_valid;
   logic             o_overrun;
   logic [5:0]       o_cnt;

   int unsigned errors = 0;
   int unsigned checks = 0;

   s_to_p_no_cp #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .i_start(i_start), .i_strobe(i_strobe),
      .i_X(i_X), .i_ack(i_ack),
      .Y0(y[0]),   .Y1(y[1]),   .Y2(y[2]),   .Y3(y[3]),   .Y4(y[4]),   .Y5(y[5]),
      .Y6(y[6]),   .Y7(y[7]),   .Y8(y[8]),   .Y9(y[9]),   .Y10(y[10]), .Y11(y[11]),
      .Y12(y[12]), .Y13(y[13]), .Y14(y[14]), .Y15(y[15]), .Y16(y[16]), .Y17(y[17]),
      .Y18(y[18]), .Y19(y[19]), .Y20(y[20]), .Y21(y[21]), .Y22(y[22]), .Y23(y[23]),
      .Y24(y[24]), .Y25(y[25]), .Y26(y[26]), .Y27(y[27]), .Y28(y[28]), .Y29(y[29]),
      .Y30(y[30]), .Y31(y[31]), .Y32(y[32]), .Y33(y[33]), .Y34(y[34]), .Y35(y[35]),
      .Y36(y[36]), .Y37(y[37]), .Y38(y[38]), .Y39(y[39]), .Y40(y[40]), .Y41(y[41]),
      .Y42(y[42]), .Y43(y[43]), .Y44(y[44]), .Y45(y[45]), .Y46(y[46]), .Y47(y[47]),
      .Y48(y[48]), .Y49(y[49]), .Y50(y[50]), .Y51(y[51]), .Y52(y[52]), .Y53(y[53]),
      .Y54(y[54]), .Y55(y[55]), .Y56(y[56]), .Y57(y[57]), .Y58(y[58]), .Y59(y[59]),
      .Y60(y[60]), .Y61(y[61]), .Y62(y[62]), .Y63(y[63]),
      .o_valid(o_valid), .o_overrun(o_overrun), .o_cnt(o_cnt)
   );

   // 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus; inputs return to idle and outputs settle 1 ns after the edge.
   task automatic step(input logic s, input logic st, input logic [WIDTH-1:0] x, input logic a);
      i_start  = s;
      i_strobe = st;
      i_X      = x;
      i_ack    = a;
      @(posedge clk);
      #1;
      i_start  = 1'b0;
      i_strobe = 1'b0;
      i_ack    = 1'b0;
   endtask

   // n strobes of a constant sample; gap inserts an idle cycle after each.
   task automatic send_n(input int n, input logic [WIDTH-1:0] x, input logic gap);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b1, x, 1'b0);
         if (gap) step(1'b0, 1'b0, '0, 1'b0);
      end
   endtask

   initial begin
      int rises;
      int rise_at [2];
      logic prev_valid;

      reset    = 1'b0;
      i_start  = 1'b0;
      i_strobe = 1'b0;
      i_X      = '0;
      i_ack    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_valid",   32'(o_valid),   32'h0);
      check_eq("rst_overrun", 32'(o_overrun), 32'h0);
      check_eq("rst_cnt",     32'(o_cnt),     32'h0);
      check_eq("rst_y0",      32'(y[0]),      32'h0);
      reset = 1'b1;

      // Strobes before arming are ignored.
      send_n(10, 10'h155, 1'b1);
      check_eq("idle_cnt", 32'(o_cnt), 32'h0);

      // Basic capture, one strobe every second cycle, Yn = n.
      step(1'b1, 1'b0, '0, 1'b0);
      check_eq("arm_cnt", 32'(o_cnt), 32'h0);
      for (int n = 0; n < 63; n++) begin
         step(1'b0, 1'b1, 10'(32'h200 + n), 1'b0);
         step(1'b0, 1'b0, '0, 1'b0);
      end
      check_eq("basic_cnt63",   32'(o_cnt),   32'd63);
      check_eq("basic_pre_val", 32'(o_valid), 32'h0);
      check_eq("basic_pre_y0",  32'(y[0]),    32'h0);
      step(1'b0, 1'b1, 10'h23F, 1'b0);
      check_eq("basic_valid", 32'(o_valid),   32'h1);
      check_eq("basic_cnt",   32'(o_cnt),     32'h0);
      check_eq("basic_ovr",   32'(o_overrun), 32'h0);
      for (int n = 0; n < 64; n += 9) begin
         check_eq($sformatf("basic_y%0d", n), 32'(y[n]), 32'(n));
      end
      check_eq("basic_y63", 32'(y[63]), 32'd63);
      step(1'b0, 1'b0, '0, 1'b1);
      check_eq("basic_ack", 32'(o_valid), 32'h0);
      step(1'b0, 1'b0, '0, 1'b1);
      check_eq("ack_idle", 32'(o_valid), 32'h0);

      // Conversion extremes at indices 0..2.
      step(1'b1, 1'b0, '0, 1'b0);
      step(1'b0, 1'b1, 10'h000, 1'b0);
      step(1'b0, 1'b1, 10'h3FF, 1'b0);
      step(1'b0, 1'b1, 10'h200, 1'b0);
      send_n(61, 10'h200, 1'b0);
      check_eq("ext_valid", 32'(o_valid), 32'h1);
      check_eq("ext_y0",    32'(y[0]),    32'h200);
      check_eq("ext_y1",    32'(y[1]),    32'h1FF);
      check_eq("ext_y2",    32'(y[2]),    32'h000);
      step(1'b0, 1'b0, '0, 1'b1);

      // Re-alignment: second i_start with coincident strobe becomes index 0.
      step(1'b1, 1'b0, '0, 1'b0);
      send_n(20, 10'h2FF, 1'b1);
      check_eq("realn_cnt20", 32'(o_cnt), 32'd20);
      step(1'b1, 1'b1, 10'h2AA, 1'b0);
      check_eq("realn_cnt1", 32'(o_cnt), 32'd1);
      send_n(62, 10'h205, 1'b1);
      check_eq("realn_pre_val", 32'(o_valid), 32'h0);
      send_n(1, 10'h205, 1'b1);
      check_eq("realn_valid", 32'(o_valid), 32'h1);
      check_eq("realn_y0",    32'(y[0]),    32'h0AA);
      check_eq("realn_y1",    32'(y[1]),    32'h005);
      check_eq("realn_y63",   32'(y[63]),   32'h005);
      step(1'b0, 1'b0, '0, 1'b1);

      // i_start outranks completion at index 63.
      send_n(63, 10'h210, 1'b0);
      check_eq("prio_cnt63", 32'(o_cnt), 32'd63);
      step(1'b1, 1'b1, 10'h211, 1'b0);
      check_eq("prio_valid", 32'(o_valid), 32'h0);
      check_eq("prio_cnt",   32'(o_cnt),   32'd1);
      check_eq("prio_y0",    32'(y[0]),    32'h0AA);

      // Handshake: completion with ack keeps valid, then overrun on unacked completion.
      step(1'b1, 1'b0, '0, 1'b0);
      send_n(64, 10'h201, 1'b1);
      check_eq("symA_valid", 32'(o_valid), 32'h1);
      check_eq("symA_y0",    32'(y[0]),    32'h001);
      send_n(63, 10'h202, 1'b1);
      step(1'b0, 1'b1, 10'h202, 1'b1);
      check_eq("coin_valid", 32'(o_valid),   32'h1);
      check_eq("coin_ovr",   32'(o_overrun), 32'h0);
      check_eq("coin_y0",    32'(y[0]),      32'h002);
      send_n(64, 10'h203, 1'b1);
      check_eq("ovr_flag",  32'(o_overrun), 32'h1);
      check_eq("ovr_valid", 32'(o_valid),   32'h1);
      check_eq("ovr_y0",    32'(y[0]),      32'h003);
      check_eq("ovr_y63",   32'(y[63]),     32'h003);
      step(1'b0, 1'b0, '0, 1'b1);
      check_eq("ovr_ack_valid", 32'(o_valid),   32'h0);
      check_eq("ovr_sticky",    32'(o_overrun), 32'h1);

      // Back-to-back strobes: two symbols, 64 cycles apart.
      step(1'b1, 1'b0, '0, 1'b0);
      rises      = 0;
      rise_at[0] = -1;
      rise_at[1] = -1;
      prev_valid = o_valid;
      for (int k = 0; k < 128; k++) begin
         step(1'b0, 1'b1, 10'(32'h200 + k), (k == 64) ? 1'b1 : 1'b0);
         if (o_valid && !prev_valid) begin
            if (rises < 2) rise_at[rises] = k;
            rises++;
         end
         prev_valid = o_valid;
         if (k == 63) begin
            check_eq("b2b_s1_y0",  32'(y[0]),  32'd0);
            check_eq("b2b_s1_y40", 32'(y[40]), 32'd40);
            check_eq("b2b_s1_y63", 32'(y[63]), 32'd63);
         end
         if (k == 64) check_eq("b2b_ack", 32'(o_valid), 32'h0);
         if (k == 127) begin
            check_eq("b2b_s2_y0",  32'(y[0]),  32'd64);
            check_eq("b2b_s2_y10", 32'(y[10]), 32'd74);
            check_eq("b2b_s2_y63", 32'(y[63]), 32'd127);
         end
      end
      check_eq("b2b_rises", 32'(rises), 32'd2);
      check_eq("b2b_first", 32'(rise_at[0]), 32'd63);
      check_eq("b2b_gap",   32'(rise_at[1] - rise_at[0]), 32'd64);
      step(1'b0, 1'b0, '0, 1'b1);
      check_eq("b2b_ack2", 32'(o_valid), 32'h0);

      // Asynchronous reset mid-symbol with valid and overrun set.
      step(1'b1, 1'b0, '0, 1'b0);
      send_n(64, 10'h2AB, 1'b0);
      send_n(30, 10'h2CD, 1'b0);
      check_eq("pre_rst_valid", 32'(o_valid),   32'h1);
      check_eq("pre_rst_ovr",   32'(o_overrun), 32'h1);
      check_eq("pre_rst_cnt",   32'(o_cnt),     32'd30);
      #2;
      reset = 1'b0;
      #1;
      check_eq("arst_valid", 32'(o_valid),   32'h0);
      check_eq("arst_ovr",   32'(o_overrun), 32'h0);
      check_eq("arst_cnt",   32'(o_cnt),     32'h0);
      check_eq("arst_y0",    32'(y[0]),      32'h0);
      check_eq("arst_y63",   32'(y[63]),     32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      send_n(5, 10'h2EE, 1'b1);
      check_eq("post_rst_cnt",   32'(o_cnt),   32'h0);
      check_eq("post_rst_valid", 32'(o_valid), 32'h0);
      step(1'b1, 1'b1, 10'h2EE, 1'b0);
      check_eq("post_rst_arm", 32'(o_cnt), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/s_to_p_no_cp.md
# s_to_p_no_cp

Receive-side serial-to-parallel converter for the OFDM chain without cyclic prefix. It captures offset-binary ADC samples, one per strobe, into 64-entry symbols and converts each sample to two's complement. Each completed symbol is presented as 64 parallel words (Y0..Y63) to the FFT stage. A valid/ack handshake and a sticky overrun flag sit on the output side.

## Interface
- WIDTH, 10, sample width in bits (offset-binary in, two's complement out)
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- i_start  input  1  one-cycle pulse; arms capture and aligns symbol boundary (sample index 0)
- i_strobe  input  1  one-cycle sample enable; i_X is valid when high
- i_X  input  WIDTH  serial sample, offset-binary (0x200 = mid-scale for WIDTH=10)
- i_ack  input  1  downstream has consumed current Y0..Y63
- Y0..Y63  output  WIDTH each  parallel symbol, two's complement, registered
- o_valid  output  1  Y0..Y63 hold an unconsumed symbol
- o_overrun  output  1  sticky: a symbol completed while previous one was unacknowledged
- o_cnt  output  6  index the next strobed sample will be written to (debug)

## Operation
- Conversion: stored value = i_X XOR (1 << (WIDTH-1)), i.e. MSB flipped; no other arithmetic.
- Storage: 63-entry capture buffer r_mem[0..62] plus 64 output registers (double buffering). Y0..Y63 change only on symbol completion.
- State IDLE (reset state): i_strobe is ignored, r_cnt = 0.
  - i_start: enter CAPTURE. If i_strobe is high in the same cycle, that sample is stored as index 0 and r_cnt becomes 1. Otherwise r_cnt stays 0.
- State CAPTURE: on i_strobe, write the converted sample to r_mem[r_cnt] and set r_cnt <= r_cnt+1.
  - On i_strobe with r_cnt == 63 (symbol complete): load Y0..Y62 from r_mem[0..62] and Y63 from the converted i_X directly. Set o_valid <= 1 and r_cnt <= 0 (wrap). Stay in CAPTURE; capture is continuous, symbol after symbol.
  - i_start in CAPTURE: re-align. The partial symbol is discarded and r_cnt resets. The strobe rule is the same as in IDLE: a coincident strobe sample becomes index 0.
  - i_start has priority over completion: i_start + i_strobe with r_cnt == 63 restarts and does NOT update Y or o_valid.
- Handshake:
  - i_ack with o_valid=1 clears o_valid on the next edge.
  - If completion and i_ack occur in the same cycle, o_valid stays 1 and the new data is loaded.
  - i_ack with o_valid=0 has no effect.
- Overrun: completion while o_valid=1 and i_ack=0 sets o_overrun <= 1. Y is still overwritten with the new symbol, and o_valid stays 1. o_overrun clears only on reset.
- No exit from CAPTURE other than reset.
- Reset (any time, asynchronous): state IDLE; r_cnt, r_mem, Y0..Y63, o_valid and o_overrun all 0. A partial symbol is lost.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: Y0..Y63 = 0, o_valid = 0, o_overrun = 0, o_cnt = 0.
- Latency: the 64th strobe (rising edge k) makes Y0..Y63 and o_valid visible after edge k.
- Strobe rate: up to one per clk (back-to-back strobes are legal). The nominal rate is one per 2 clk, matching the transmit-side output clock.
- After o_valid rises, the consumer has 64 strobe periods to assert i_ack before an overrun.
- Reset release is synchronous to clk by the integrating top level; the block assumes deassertion meets recovery timing.

## Test plan
- Basic capture, WIDTH=10: pulse i_start, then 64 strobes every 2nd cycle with i_X = 0x200+n (n=0..63). Required: o_valid rises after the 64th strobe edge; Yn = n (Y0=0, Y63=63); o_cnt wraps to 0.
- Conversion extremes: i_X = 0x000, 0x3FF and 0x200 at indices 0, 1 and 2. Required: Y0=0x200 (-512), Y1=0x1FF (+511), Y2=0x000.
- Strobe before arming and re-alignment:
  - 10 strobes in IDLE are ignored (o_cnt stays 0).
  - Then i_start, 20 strobes, and a second i_start coincident with a strobe of i_X=0x2AA.
  - Required: after 63 further strobes, o_valid=1 and Y0=0x0AA.
- Handshake and overrun:
  - Complete symbol A, hold i_ack=0, complete symbol B. Required: o_overrun=1 (sticky), Y holds B, o_valid=1.
  - Then pulse i_ack: o_valid=0 on the next edge, o_overrun still 1.
  - Completion coincident with i_ack: o_valid stays 1, no new overrun.
- Back-to-back strobes: 128 consecutive strobes (one per clk) after i_start. Required: exactly two o_valid assertions, 64 cycles apart, with i_ack pulsed after each; correct data in both symbols.
- Reset mid-symbol: assert reset (low) asynchronously after 30 strobes while o_valid=1 and o_overrun=1. Required: all outputs are 0 immediately, without waiting for a clk edge. After release, strobes are ignored until i_start.
